fp_divide_iter: RTL and testbench

//  Iterative, handshaked IEEE-754 divider, parametrised in exponent/mantissa width (default FP32).

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_round_rne.sv | 43 ++++
 rtl/fp_divide_iter.sv | 182 ++++++++++++++++++
 tb/tb_fp_divide_iter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the iterative divider and its siblings.
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_t;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND, S_DONE} div_state_t;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 2**(FP32_EXP_W-1) - 1;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Exponent bias for an arbitrary exponent width.
  function automatic int fp_bias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Subnormals are flushed: a zero exponent is always treated as zero.
  function automatic fp_class_t fp_classify(input logic expZero, input logic expOnes,
                                            input logic fracZero);
    if (expZero)       return FP_ZERO;
    else if (!expOnes) return FP_NORMAL;
    else if (fracZero) return FP_INF;
    else               return FP_NAN;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational rounding/renormalise/range-check stage, shared with the multiplier.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W         = 8,
  parameter int MAN_W         = 23,
  parameter int ROUND_NEAREST = 1
) (
  input  logic [MAN_W:0]          mant,      // normalised mantissa incl. hidden bit
  input  logic                    guard,
  input  logic                    roundBit,
  input  logic                    sticky,
  input  logic signed [EXP_W+1:0] expIn,
  output logic [MAN_W-1:0]        frac,
  output logic [EXP_W-1:0]        expOut,
  output logic                    ovf,
  output logic                    unf
);

  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);

  logic                    inc;
  logic [MAN_W+1:0]        sum;
  logic signed [EXP_W+1:0] expAdj;

  // Round-half-even increment, carry-out renormalisation, then range check.
  always_comb begin
    inc    = (ROUND_NEAREST != 0) && guard && (roundBit || sticky || mant[0]);
    sum    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    frac   = sum[MAN_W-1:0];
    expAdj = expIn;
    if (sum[MAN_W+1]) begin
      frac   = sum[MAN_W:1];
      expAdj = expIn + EXP_ONE;
    end
    ovf    = (expAdj >= EXP_MAX);
    unf    = (expAdj <= EXP_ZERO);
    expOut = expAdj[EXP_W-1:0];
  end

endmodule

// File: rtl/fp_divide_iter.sv
// Iterative restoring IEEE-754 divider: one quotient bit per cycle, single op in flight.
module fp_divide_iter
  import fp_pkg::*;
#(
  parameter int EXP_W         = 8,
  parameter int MAN_W         = 23,
  parameter int ROUND_NEAREST = 1,
  localparam int W            = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] inputA,
  input  logic [W-1:0] inputB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         flag_dbz,
  output logic         flag_invalid,
  output logic         flag_ovf,
  output logic         flag_unf
);

  localparam int QW    = MAN_W + 3;          // int bit, fraction, guard, round
  localparam int CNT_W = $clog2(MAN_W + 4);
  localparam logic [EXP_W+1:0]        BIAS_X  = (EXP_W+2)'(fp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);
  localparam logic [CNT_W-1:0]        ITERS   = CNT_W'(MAN_W + 3);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] INF_MAG = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  div_state_t              state;
  logic                    sgnR;
  logic signed [EXP_W+1:0] expR;
  logic [MAN_W+1:0]        rem;
  logic [MAN_W:0]          div;
  logic [QW-1:0]           q;
  logic [CNT_W-1:0]        cnt;

  // operand decode
  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] fracA, fracB;
  fp_class_t        clsA, clsB;
  logic             sgn;

  assign expA  = inputA[W-2:MAN_W];
  assign expB  = inputB[W-2:MAN_W];
  assign fracA = inputA[MAN_W-1:0];
  assign fracB = inputB[MAN_W-1:0];
  assign clsA  = fp_classify(expA == '0, &expA, fracA == '0);
  assign clsB  = fp_classify(expB == '0, &expB, fracB == '0);
  assign sgn   = inputA[W-1] ^ inputB[W-1];

  logic         isSpecial, specDbz, specInv;
  logic [W-1:0] specOut;

  // Special-operand result, resolved in priority order at accept time.
  always_comb begin
    isSpecial = !(clsA == FP_NORMAL && clsB == FP_NORMAL);
    specDbz   = 1'b0;
    specInv   = 1'b0;
    specOut   = {sgn, {(W-1){1'b0}}};
    if (clsA == FP_NAN || clsB == FP_NAN) begin
      specOut = QNAN;
      specInv = 1'b1;
    end else if ((clsA == FP_ZERO && clsB == FP_ZERO) || (clsA == FP_INF && clsB == FP_INF)) begin
      specOut = QNAN;
      specInv = 1'b1;
    end else if (clsA == FP_INF) begin
      specOut = {sgn, INF_MAG[W-2:0]};
    end else if (clsB == FP_ZERO) begin
      specOut = {sgn, INF_MAG[W-2:0]};
      specDbz = 1'b1;
    end
  end

  // restoring step
  logic             remGe;
  logic [MAN_W+1:0] remNext;

  assign remGe   = (rem >= {1'b0, div});
  assign remNext = remGe ? (rem - {1'b0, div}) : rem;

  // normalisation ahead of rounding
  logic [MAN_W:0]          mantN;
  logic                    guardN, roundN;
  logic signed [EXP_W+1:0] expN;

  // A quotient below 1.0 gives up one bit and one exponent step.
  always_comb begin
    mantN  = q[QW-1:2];
    guardN = q[1];
    roundN = q[0];
    expN   = expR;
    if (!q[QW-1]) begin
      mantN  = q[QW-2:1];
      guardN = q[0];
      roundN = 1'b0;
      expN   = expR - EXP_ONE;
    end
  end

  logic [MAN_W-1:0] fracRnd;
  logic [EXP_W-1:0] expRnd;
  logic             ovfRnd, unfRnd;

  fp_round_rne #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_NEAREST(ROUND_NEAREST)
  ) uRound (
    .mant(mantN), .guard(guardN), .roundBit(roundN), .sticky(|rem),
    .expIn(expN), .frac(fracRnd), .expOut(expRnd), .ovf(ovfRnd), .unf(unfRnd)
  );

  // Control FSM plus datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out          <= '0;
      flag_dbz     <= 1'b0;
      flag_invalid <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      sgnR         <= 1'b0;
      expR         <= '0;
      rem          <= '0;
      div          <= '0;
      q            <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (isSpecial) begin
            out          <= specOut;
            flag_dbz     <= specDbz;
            flag_invalid <= specInv;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else begin
            sgnR  <= sgn;
            expR  <= {2'b00, expA} - {2'b00, expB} + BIAS_X;
            rem   <= {2'b01, fracA};
            div   <= {1'b1, fracB};
            q     <= '0;
            cnt   <= ITERS;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          q   <= {q[QW-2:0], remGe};
          rem <= remNext << 1;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_ROUND;
        end
        S_ROUND: begin
          if (ovfRnd)      out <= {sgnR, INF_MAG[W-2:0]};
          else if (unfRnd) out <= {sgnR, {(W-1){1'b0}}};
          else             out <= {sgnR, expRnd, fracRnd};
          flag_ovf  <= ovfRnd;
          flag_unf  <= unfRnd;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid    <= 1'b0;
          in_ready     <= 1'b1;
          flag_dbz     <= 1'b0;
          flag_invalid <= 1'b0;
          flag_ovf     <= 1'b0;
          flag_unf     <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divide_iter.sv
// Directed-vector bench for fp_divide_iter: RNE and truncating instances run in lockstep.
module tb_fp_divide_iter;

  logic        clk = 1'b0;
  logic        reset, inValid, outReady;
  logic [31:0] inputA, inputB;

  logic        inReady, outValid, dbz, inv, ovf, unf;
  logic [31:0] outQ;
  logic        inReadyT, outValidT, dbzT, invT, ovfT, unfT;
  logic [31:0] outT;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  fp_divide_iter #(.EXP_W(8), .MAN_W(23), .ROUND_NEAREST(1)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .inputA(inputA), .inputB(inputB), .out_valid(outValid), .out_ready(outReady),
    .out(outQ), .flag_dbz(dbz), .flag_invalid(inv), .flag_ovf(ovf), .flag_unf(unf)
  );

  fp_divide_iter #(.EXP_W(8), .MAN_W(23), .ROUND_NEAREST(0)) dutTrunc (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyT),
    .inputA(inputA), .inputB(inputB), .out_valid(outValidT), .out_ready(outReady),
    .out(outT), .flag_dbz(dbzT), .flag_invalid(invT), .flag_ovf(ovfT), .flag_unf(unfT)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRne;
    logic [31:0] expTrunc;
    logic [3:0]  flags;    // {dbz, invalid, ovf, unf}
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    int lat;
    lat = 0;
    while (!inReady && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " ready"}, {31'd0, inReady}, 32'd1);
    inputA  = v.a;
    inputB  = v.b;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " out"}, outQ, v.expRne);
    check({tag, " flags"}, {28'd0, dbz, inv, ovf, unf}, {28'd0, v.flags});
    check({tag, " trunc out"}, outT, v.expTrunc);
    check({tag, " trunc flags"}, {28'd0, dbzT, invT, ovfT, unfT}, {28'd0, v.flags});
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    check({tag, " idle after"}, {29'd0, inReady, outValid, |{dbz, inv, ovf, unf}}, 32'd4);
  endtask

  initial begin
    logic seen;
    logic [31:0] held;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 4'b0000, 28};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 4'b1000, 1};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'b0100, 1};
    vecs[4]  = '{32'hBF800000, 32'h7F800000, 32'h80000000, 32'h80000000, 4'b0000, 1};
    vecs[5]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800000, 4'b0010, 28};
    vecs[6]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 32'h00000000, 4'b0001, 28};
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b0100, 1};
    vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 4'b0100, 1};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'b0000, 1};
    vecs[10] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 4'b0000, 28};
    vecs[11] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28};

    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    inputA   = '0;
    inputB   = '0;
    repeat (3) @(negedge clk);
    check("reset state", {26'd0, inReady, outValid, dbz, inv, ovf, unf}, 32'h20);
    check("reset out", outQ, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // back-pressure: result must hold while out_ready is low
    inputA  = 32'h40C00000;
    inputB  = 32'h40000000;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    for (int i = 0; i < 200 && !outValid; i++) @(negedge clk);
    check("hold first valid", {31'd0, outValid}, 32'd1);
    held = outQ;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold out c%0d", i), outQ, 32'h40400000);
      check($sformatf("hold hs c%0d", i), {30'd0, outValid, inReady}, 32'd2);
    end
    check("hold vs first", outQ, held);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    check("hold release", {30'd0, inReady, outValid}, 32'd2);

    // reset mid-iteration aborts the op without emitting a result
    inputA  = 32'h40C00000;
    inputB  = 32'h40000000;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    seen = outValid;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      seen = seen | outValid;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = seen | outValid;
    check("abort no valid", {31'd0, seen}, 32'd0);
    check("abort ready", {31'd0, inReady}, 32'd1);
    runVec(vecs[0], "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
